// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the two-source edge-detection frame arbiter.
package edge_arb_pkg;

    localparam int unsigned RGB_W   = 24;
    localparam int unsigned SOBEL_W = 8;
    localparam int unsigned FCNT_W  = 16;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    function automatic int unsigned frame_pixels(input int unsigned width,
                                                 input int unsigned height);
        return width * height;
    endfunction

    // Ties go to the source that did not win last time.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/edge_frame_arbiter_if.sv
// FIFO-side signals of the arbiter: two sources, the shared pipeline and two destinations.
interface edge_frame_arbiter_if;
    import edge_arb_pkg::*;

    logic               src0_empty;
    logic               src1_empty;
    logic [RGB_W-1:0]   src0_dout;
    logic [RGB_W-1:0]   src1_dout;
    logic               src0_rd_en;
    logic               src1_rd_en;

    logic               pipe_in_full;
    logic               pipe_in_wr_en;
    logic [RGB_W-1:0]   pipe_in_din;

    logic               pipe_out_empty;
    logic [SOBEL_W-1:0] pipe_out_dout;
    logic               pipe_out_rd_en;

    logic               dst0_full;
    logic               dst1_full;
    logic               dst0_wr_en;
    logic               dst1_wr_en;
    logic [SOBEL_W-1:0] dst0_din;
    logic [SOBEL_W-1:0] dst1_din;

    modport master (
        input  src0_empty, src1_empty, src0_dout, src1_dout,
        output src0_rd_en, src1_rd_en,
        input  pipe_in_full,
        output pipe_in_wr_en, pipe_in_din,
        input  pipe_out_empty, pipe_out_dout,
        output pipe_out_rd_en,
        input  dst0_full, dst1_full,
        output dst0_wr_en, dst1_wr_en, dst0_din, dst1_din
    );

    modport slave (
        output src0_empty, src1_empty, src0_dout, src1_dout,
        input  src0_rd_en, src1_rd_en,
        output pipe_in_full,
        input  pipe_in_wr_en, pipe_in_din,
        output pipe_out_empty, pipe_out_dout,
        input  pipe_out_rd_en,
        output dst0_full, dst1_full,
        input  dst0_wr_en, dst1_wr_en, dst0_din, dst1_din
    );

endinterface

// File: rtl/edge_px_counter.sv
// Per-frame pixel counter with terminal flags at N-1 and N.
module edge_px_counter #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last,
    output logic         full
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == W'(N - 1));
    assign full = (count == W'(N));

endmodule

// File: rtl/edge_frame_arbiter.sv
// Time-shares one edge-detection pipeline between two pixel sources, one whole frame
// at a time, round-robin, steering results back to the matching destination.
module edge_frame_arbiter
    import edge_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = 720,
    parameter int unsigned HEIGHT = 540
) (
    input  logic                  clock,
    input  logic                  reset,
    edge_frame_arbiter_if.master  bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_src,
    output logic [FCNT_W-1:0]     frame_cnt0,
    output logic [FCNT_W-1:0]     frame_cnt1
);

    localparam int unsigned N  = frame_pixels(WIDTH, HEIGHT);
    localparam int unsigned CW = $clog2(N + 1);

    state_t          state;
    logic            sel;
    logic            last_grant;
    logic            req0, req1;
    logic            src_empty, dst_full;
    logic            in_xfer, out_xfer;
    logic            cnt_clear;
    logic            in_last, in_full, out_last, out_full;
    logic [CW-1:0]   in_cnt, out_cnt;
    logic            unused_cnt;

    assign req0      = ~bus.src0_empty;
    assign req1      = ~bus.src1_empty;
    assign src_empty = sel ? bus.src1_empty : bus.src0_empty;
    assign dst_full  = sel ? bus.dst1_full  : bus.dst0_full;

    assign in_xfer   = (state == FEED) & ~src_empty & ~bus.pipe_in_full;
    // Gating on out_full keeps a misbehaving pipeline from leaking into the next frame.
    assign out_xfer  = ((state == FEED) | (state == DRAIN)) & ~bus.pipe_out_empty & ~dst_full
                       & ~out_full;
    assign cnt_clear = (state == IDLE) & (req0 | req1);

    assign bus.src0_rd_en     = in_xfer & ~sel;
    assign bus.src1_rd_en     = in_xfer & sel;
    assign bus.pipe_in_wr_en  = in_xfer;
    assign bus.pipe_in_din    = sel ? bus.src1_dout : bus.src0_dout;
    assign bus.pipe_out_rd_en = out_xfer;
    assign bus.dst0_wr_en     = out_xfer & ~sel;
    assign bus.dst1_wr_en     = out_xfer & sel;
    assign bus.dst0_din       = bus.pipe_out_dout;
    assign bus.dst1_din       = bus.pipe_out_dout;

    assign frame_src  = sel;
    assign unused_cnt = ^{in_cnt, out_cnt, in_full};

    edge_px_counter #(.N(N)) u_in_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (in_xfer),
        .count (in_cnt),
        .last  (in_last),
        .full  (in_full)
    );

    edge_px_counter #(.N(N)) u_out_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (out_xfer),
        .count (out_cnt),
        .last  (out_last),
        .full  (out_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel   <= rr_pick(req0, req1, last_grant);
                        state <= FEED;
                        busy  <= 1'b1;
                    end
                end
                FEED: begin
                    if (in_xfer && in_last) begin
                        if (out_full || (out_xfer && out_last)) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_xfer && out_last) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (sel) begin
                        frame_cnt1 <= frame_cnt1 + 1'b1;
                    end else begin
                        frame_cnt0 <= frame_cnt0 + 1'b1;
                    end
                    last_grant <= sel;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/edge_frame_arbiter.md
# edge_frame_arbiter

- Shares one `edge_detection_top` pipeline between two RGB pixel sources, one whole frame at a time, with round-robin grant.
- Pops 24-bit pixels from the granted source's FWFT FIFO into the pipeline input FIFO.
- Steers the pipeline's 8-bit Sobel output to the matching destination FIFO.
- Keeps exactly one frame in flight, so output frames never interleave.

## Interface
- WIDTH, 720, frame width in pixels
- HEIGHT, 540, frame height in pixels
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- src0_empty / src1_empty  in  1  source FIFO empty (FWFT)
- src0_dout / src1_dout  in  24  source pixel, valid while the matching empty flag is low
- src0_rd_en / src1_rd_en  out  1  pop the matching source FIFO
- pipe_in_full  in  1  pipeline input FIFO full
- pipe_in_wr_en  out  1  pipeline input write
- pipe_in_din  out  24  pipeline input pixel
- pipe_out_empty  in  1  pipeline output FIFO empty (FWFT)
- pipe_out_dout  in  8  pipeline output pixel
- pipe_out_rd_en  out  1  pipeline output pop
- dst0_full / dst1_full  in  1  destination FIFO full
- dst0_wr_en / dst1_wr_en  out  1  destination write
- dst0_din / dst1_din  out  8  destination pixel, both driven with pipe_out_dout
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of a frame
- frame_src  out  1  source of the current or last frame
- frame_cnt0 / frame_cnt1  out  16  completed frames per source, wraps at 0xFFFF→0

## Operation
- Frame size N = WIDTH*HEIGHT. Pixel counters are $clog2(N+1) bits wide.
- FSM states:
  - IDLE: wait for a source request.
  - FEED: transfer input pixels; output transfers may also occur.
  - DRAIN: output transfers only.
  - DONE: end-of-frame bookkeeping.
- Request k = !srck_empty.
- IDLE arbitration:
  - One request: grant that source.
  - Both request: grant the source other than last_grant.
  - Grant is latched into sel. Next state FEED; in_cnt and out_cnt cleared.
- Input transfer: in_xfer = (state==FEED) & !src[sel]_empty & !pipe_in_full, combinational.
  - In the same cycle: src[sel]_rd_en=1, pipe_in_wr_en=1, pipe_in_din=src[sel]_dout.
- Output transfer: out_xfer = (state==FEED|DRAIN) & !pipe_out_empty & !dst[sel]_full, combinational.
  - In the same cycle: pipe_out_rd_en=1, dst[sel]_wr_en=1.
- The unselected source rd_en and unselected destination wr_en are always 0.
- FEED→DRAIN on in_xfer with in_cnt==N-1.
- DRAIN→DONE on out_xfer with out_cnt==N-1.
- If out_cnt has already reached N when the last input pixel transfers, FEED goes directly to DONE.
- DONE, one cycle:
  - frame_done=1.
  - frame_cnt[sel] increments.
  - last_grant<=sel.
  - Next state IDLE.
- frame_src = sel.
- Output pixels present in IDLE are not consumed. The pipeline never emits them in correct use; they stay in the pipeline FIFO.
- Output transfers past N within a frame cannot occur: out_xfer is gated off once out_cnt==N.

## Timing
- Reset (async assert, synchronous release) sets:
  - state=IDLE, sel=0, last_grant=1, so src0 wins the first tie.
  - All counters 0.
  - All rd_en/wr_en 0, busy=0, frame_done=0.
- Reset mid-frame abandons the frame. The pipeline must be reset alongside; the arbiter itself does not flush.
- A request seen in IDLE at cycle t produces FEED at t+1, with the first in_xfer possible at t+1.
- Input and output paths are combinational from the empty/full flags. There are no registered data stages and no added latency.
- Peak input rate: 1 pixel/cycle.
- Gap between frames: DONE plus IDLE, 2 cycles minimum.
- Back-pressure from pipe_in_full or dst_full stalls only the affected path. Counters hold while stalled.
- Simultaneous in_xfer and out_xfer are both counted in the same cycle.

## Structure
- Package edge_arb_pkg:
  - state_t enum {IDLE, FEED, DRAIN, DONE}.
  - Function frame_pixels(WIDTH,HEIGHT).
  - Function rr_pick(req0, req1, last_grant).
- Sub-module edge_px_counter:
  - Parameterised by N.
  - Ports: clear, inc, count, last (count==N-1), full (count==N).
  - Instantiated twice, for in_cnt and out_cnt.

## Test plan
- WIDTH=4, HEIGHT=2 (N=8) for all scenarios.
1. Single source, no back-pressure: src0 holds 8 pixels, dst0 never full.
   - 8 pipe writes, then 8 writes to dst0.
   - frame_done pulse; frame_src=0; frame_cnt0=1.
   - dst1_wr_en never asserted.
2. Both sources loaded with 2 frames each from reset.
   - Grant order src0, src1, src0, src1.
   - Each frame's 8 outputs land in the matching destination; frame_cnt0=frame_cnt1=2.
3. Back-pressure: toggle pipe_in_full every cycle and hold dst0_full high for 5 cycles mid-frame.
   - No pixel lost or duplicated; in_cnt and out_cnt each end at 8.
4. One frame in flight: src1 requests while src0's frame is draining.
   - Zero src1_rd_en until after src0's DONE; src1 granted 2 cycles after the last dst0 write.
5. Reset asserted with in_cnt=5.
   - Immediately all enables 0, busy=0.
   - After release and pipeline reset, a fresh src0 frame completes with frame_cnt0=1.
6. Frame-counter wrap: preload via 65536 completed src0 frames (or force) → frame_cnt0 reads 0; frame_cnt1 unchanged.
